// File: rtl/dn_router.sv
// dn_router: routes HPS ioctl download bytes to the BIOS RAM or sprite ROM port.
// It packs sprite bytes into 16-bit words and holds the core in reset around a download.
module dn_router #(
    parameter int         BIOS_AW     = 16,
    parameter int         SPR_AW      = 15,
    parameter logic [7:0] BIOS_INDEX  = 8'd0,
    parameter logic [7:0] SPR_INDEX   = 8'd3,
    parameter int         HOLD_CYCLES = 16
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [24:0]         ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    input  logic [7:0]          ioctl_index,
    output logic [BIOS_AW-1:0]  bios_addr,
    output logic [7:0]          bios_data,
    output logic                bios_wr,
    output logic [SPR_AW-1:0]   spr_addr,
    output logic [15:0]         spr_data,
    output logic                spr_wr,
    output logic                core_reset_hold,
    output logic                busy,
    output logic                dn_error,
    output logic [16:0]         bytes_loaded
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, HOLD} state_t;

    localparam logic [24:0] BIOS_LIMIT = 25'(2 ** BIOS_AW);
    localparam logic [24:0] SPR_LIMIT  = 25'(2 ** (SPR_AW + 1));
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYCLES - 1);

    state_t            state;
    logic              download_q;
    logic [7:0]        index_q;
    logic              pend_valid;
    logic [7:0]        pend_byte;
    logic [SPR_AW-1:0] pend_addr;
    logic              skid_valid;
    logic [SPR_AW-1:0] skid_addr;
    logic [15:0]       skid_data;
    logic [7:0]        hold_cnt;

    logic              dl_rise;
    logic              new_routed;
    logic              start_load;
    logic              route_bios;
    logic              route_spr;
    logic              bios_in_range;
    logic              spr_in_range;
    logic [SPR_AW-1:0] word_addr;
    logic              pend_next;

    // Decode the current byte and the download start condition.
    always_comb begin
        dl_rise       = ioctl_download & ~download_q;
        new_routed    = (ioctl_index == BIOS_INDEX) || (ioctl_index == SPR_INDEX);
        start_load    = dl_rise && new_routed && ((state == IDLE) || (state == HOLD));
        route_bios    = (index_q == BIOS_INDEX);
        route_spr     = (index_q == SPR_INDEX) && !route_bios;
        bios_in_range = (ioctl_addr < BIOS_LIMIT);
        spr_in_range  = (ioctl_addr < SPR_LIMIT);
        word_addr     = ioctl_addr[SPR_AW:1];
        pend_next     = pend_valid;
        if (ioctl_wr && route_spr && spr_in_range) begin
            pend_next = ~ioctl_addr[0];
        end
    end

    // Main state machine with registered strobes, packing and reset hold.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            download_q      <= 1'b0;
            index_q         <= 8'h00;
            pend_valid      <= 1'b0;
            pend_byte       <= 8'h00;
            pend_addr       <= '0;
            skid_valid      <= 1'b0;
            skid_addr       <= '0;
            skid_data       <= 16'h0000;
            hold_cnt        <= 8'h00;
            bios_addr       <= '0;
            bios_data       <= 8'h00;
            bios_wr         <= 1'b0;
            spr_addr        <= '0;
            spr_data        <= 16'h0000;
            spr_wr          <= 1'b0;
            core_reset_hold <= 1'b0;
            busy            <= 1'b0;
            dn_error        <= 1'b0;
            bytes_loaded    <= 17'h00000;
        end else begin
            download_q <= ioctl_download;
            bios_wr    <= 1'b0;
            spr_wr     <= 1'b0;

            if (skid_valid) begin
                spr_wr     <= 1'b1;
                spr_addr   <= skid_addr;
                spr_data   <= skid_data;
                skid_valid <= 1'b0;
            end

            if (dl_rise && ((state == IDLE) || (state == HOLD))) begin
                index_q <= ioctl_index;
            end

            if (start_load) begin
                state           <= LOAD;
                bytes_loaded    <= 17'h00000;
                dn_error        <= 1'b0;
                pend_valid      <= 1'b0;
                hold_cnt        <= 8'h00;
                core_reset_hold <= 1'b1;
                busy            <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                    end

                    LOAD: begin
                        if (ioctl_wr && route_bios) begin
                            if (bios_in_range) begin
                                bios_wr   <= 1'b1;
                                bios_addr <= ioctl_addr[BIOS_AW-1:0];
                                bios_data <= ioctl_dout;
                                if (bytes_loaded != 17'h1FFFF) bytes_loaded <= bytes_loaded + 17'd1;
                            end else begin
                                dn_error <= 1'b1;
                            end
                        end else if (ioctl_wr && route_spr) begin
                            if (!spr_in_range) begin
                                dn_error <= 1'b1;
                            end else begin
                                if (bytes_loaded != 17'h1FFFF) bytes_loaded <= bytes_loaded + 17'd1;
                                if (!ioctl_addr[0]) begin
                                    if (pend_valid) begin
                                        spr_wr   <= 1'b1;
                                        spr_addr <= pend_addr;
                                        spr_data <= {8'h00, pend_byte};
                                    end
                                    pend_valid <= 1'b1;
                                    pend_byte  <= ioctl_dout;
                                    pend_addr  <= word_addr;
                                end else begin
                                    if (pend_valid && (pend_addr != word_addr)) begin
                                        spr_wr     <= 1'b1;
                                        spr_addr   <= pend_addr;
                                        spr_data   <= {8'h00, pend_byte};
                                        skid_valid <= 1'b1;
                                        skid_addr  <= word_addr;
                                        skid_data  <= {ioctl_dout, 8'h00};
                                    end else begin
                                        spr_wr   <= 1'b1;
                                        spr_addr <= word_addr;
                                        spr_data <= {ioctl_dout, (pend_valid ? pend_byte : 8'h00)};
                                    end
                                    pend_valid <= 1'b0;
                                end
                            end
                        end

                        if (!ioctl_download) begin
                            if (pend_next) begin
                                state <= FLUSH;
                            end else begin
                                state    <= HOLD;
                                hold_cnt <= 8'h00;
                            end
                        end
                    end

                    FLUSH: begin
                        spr_wr     <= 1'b1;
                        spr_addr   <= pend_addr;
                        spr_data   <= {8'h00, pend_byte};
                        pend_valid <= 1'b0;
                        state      <= HOLD;
                        hold_cnt   <= 8'h00;
                    end

                    HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state           <= IDLE;
                            core_reset_hold <= 1'b0;
                            busy            <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dn_router.sv
// tb_dn_router: scoreboard-driven bench for the download router.
// Expected strobes are queued as bytes are driven and popped as the DUT emits them.
module tb_dn_router;

    logic        clk_sys;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic [15:0] bios_addr;
    logic [7:0]  bios_data;
    logic        bios_wr;
    logic [14:0] spr_addr;
    logic [15:0] spr_data;
    logic        spr_wr;
    logic        core_reset_hold;
    logic        busy;
    logic        dn_error;
    logic [16:0] bytes_loaded;

    typedef struct {
        bit          is_spr;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    dn_router dut (
        .clk_sys         (clk_sys),
        .reset_n         (reset_n),
        .ioctl_download  (ioctl_download),
        .ioctl_wr        (ioctl_wr),
        .ioctl_addr      (ioctl_addr),
        .ioctl_dout      (ioctl_dout),
        .ioctl_index     (ioctl_index),
        .bios_addr       (bios_addr),
        .bios_data       (bios_data),
        .bios_wr         (bios_wr),
        .spr_addr        (spr_addr),
        .spr_data        (spr_data),
        .spr_wr          (spr_wr),
        .core_reset_hold (core_reset_hold),
        .busy            (busy),
        .dn_error        (dn_error),
        .bytes_loaded    (bytes_loaded)
    );

    // 100 MHz system clock.
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Scoreboard: every write strobe seen on a falling edge must match the oldest expectation.
    always @(negedge clk_sys) begin
        if (reset_n && bios_wr) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("[TB] FAIL bios_unexpected: got addr=%h data=%h, required no strobe", bios_addr, bios_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_spr || (bios_addr !== e.addr) || ({8'h00, bios_data} !== e.data)) begin
                    n_fails++;
                    $display("[TB] FAIL bios_strobe: got bios addr=%h data=%h, required spr=%0d addr=%h data=%h",
                             bios_addr, bios_data, e.is_spr, e.addr, e.data);
                end
            end
        end
        if (reset_n && spr_wr) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("[TB] FAIL spr_unexpected: got addr=%h data=%h, required no strobe", spr_addr, spr_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (!e.is_spr || ({1'b0, spr_addr} !== e.addr) || (spr_data !== e.data)) begin
                    n_fails++;
                    $display("[TB] FAIL spr_strobe: got spr addr=%h data=%h, required spr=%0d addr=%h data=%h",
                             spr_addr, spr_data, e.is_spr, e.addr, e.data);
                end
            end
        end
    end

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Drive one byte strobe followed by one idle cycle.
    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick(1);
        ioctl_wr   = 1'b0;
        tick(1);
    endtask

    // Queue an expected strobe.
    task automatic expect_wr(input bit is_spr, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        e.is_spr = is_spr;
        e.addr   = a;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    // Raise download with the given index and let the edge be detected.
    task automatic start_download(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick(2);
    endtask

    // Wait (bounded) for busy to drop, then confirm every expected strobe arrived.
    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 200) begin
            tick(1);
            k++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL %s_idle_timeout: got busy=%b, required 0 within 200 cycles", name, busy);
        end
        tick(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("[TB] FAIL %s_drain: got %0d strobes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, core_reset_hold, dn_error, bios_wr, spr_wr, bytes_loaded} !== 22'h0) begin
            n_fails++;
            $display("[TB] FAIL reset_initial: got busy=%b hold=%b err=%b bwr=%b swr=%b bytes=%h, required all 0",
                     busy, core_reset_hold, dn_error, bios_wr, spr_wr, bytes_loaded);
        end
        start_download(8'd3);
        send_byte(25'h10, 8'h44);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, core_reset_hold, dn_error, bios_wr, spr_wr, bytes_loaded, bios_addr, bios_data, spr_addr, spr_data} !== 77'h0) begin
            n_fails++;
            $display("[TB] FAIL reset_async: got busy=%b hold=%b bytes=%h spr_data=%h, required all 0",
                     busy, core_reset_hold, bytes_loaded, spr_data);
        end
        ioctl_download = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(6);
        n_checks++;
        if ((busy !== 1'b0) || (core_reset_hold !== 1'b0)) begin
            n_fails++;
            $display("[TB] FAIL reset_release: got busy=%b hold=%b, required 0 0", busy, core_reset_hold);
        end
        wait_idle("reset");
    endtask

    task automatic test_bios();
        int cnt;
        start_download(8'd0);
        n_checks++;
        if ((busy !== 1'b1) || (core_reset_hold !== 1'b1)) begin
            n_fails++;
            $display("[TB] FAIL bios_enter: got busy=%b hold=%b, required 1 1", busy, core_reset_hold);
        end
        expect_wr(1'b0, 16'h0000, 16'h00A5);
        send_byte(25'h0000, 8'hA5);
        expect_wr(1'b0, 16'hFFFF, 16'h003C);
        send_byte(25'hFFFF, 8'h3C);
        n_checks++;
        if (bytes_loaded !== 17'd2) begin
            n_fails++;
            $display("[TB] FAIL bios_bytes: got %0d, required 2", bytes_loaded);
        end
        ioctl_download = 1'b0;
        // One sample still in LOAD before the fall is seen, then 16 HOLD cycles.
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_sys);
            if (core_reset_hold) cnt++;
            else break;
        end
        n_checks++;
        if (cnt != 17) begin
            n_fails++;
            $display("[TB] FAIL bios_hold_len: got %0d high samples, required 17", cnt);
        end
        tick(1);
        wait_idle("bios");
    endtask

    task automatic test_sprite_pack();
        start_download(8'd3);
        send_byte(25'h0, 8'h11);
        expect_wr(1'b1, 16'h0000, 16'h2211);
        send_byte(25'h1, 8'h22);
        send_byte(25'h2, 8'h33);
        expect_wr(1'b1, 16'h0001, 16'h0033);
        ioctl_download = 1'b0;
        tick(4);
        n_checks++;
        if (bytes_loaded !== 17'd3) begin
            n_fails++;
            $display("[TB] FAIL spr_bytes: got %0d, required 3", bytes_loaded);
        end
        wait_idle("spr_pack");
    endtask

    task automatic test_back_to_back();
        start_download(8'd3);
        send_byte(25'h8, 8'h44);
        expect_wr(1'b1, 16'h0004, 16'h0044);
        expect_wr(1'b1, 16'h0005, 16'h5500);
        send_byte(25'hB, 8'h55);
        send_byte(25'hC, 8'h66);
        expect_wr(1'b1, 16'h0006, 16'h0066);
        send_byte(25'hE, 8'h77);
        send_byte(25'h10000, 8'h99);
        n_checks++;
        if ((dn_error !== 1'b1) || (bytes_loaded !== 17'd4)) begin
            n_fails++;
            $display("[TB] FAIL spr_range: got err=%b bytes=%0d, required 1 and 4", dn_error, bytes_loaded);
        end
        expect_wr(1'b1, 16'h0007, 16'h0077);
        ioctl_download = 1'b0;
        wait_idle("b2b");
        n_checks++;
        if (dn_error !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL err_sticky: got %b, required 1", dn_error);
        end
    endtask

    task automatic test_range_error();
        start_download(8'd0);
        n_checks++;
        if (dn_error !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL err_clear: got %b, required 0", dn_error);
        end
        send_byte(25'h10000, 8'h5A);
        n_checks++;
        if ((dn_error !== 1'b1) || (bytes_loaded !== 17'd0)) begin
            n_fails++;
            $display("[TB] FAIL bios_range: got err=%b bytes=%0d, required 1 and 0", dn_error, bytes_loaded);
        end
        ioctl_download = 1'b0;
        wait_idle("range");
        start_download(8'd0);
        n_checks++;
        if (dn_error !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL err_restart: got %b, required 0", dn_error);
        end
        ioctl_download = 1'b0;
        wait_idle("range2");
    endtask

    task automatic test_ignored_index();
        start_download(8'd1);
        for (int i = 0; i < 4; i++) send_byte(25'(i), 8'(8'hC0 + i));
        n_checks++;
        if ((busy !== 1'b0) || (core_reset_hold !== 1'b0)) begin
            n_fails++;
            $display("[TB] FAIL ignored: got busy=%b hold=%b, required 0 0", busy, core_reset_hold);
        end
        ioctl_download = 1'b0;
        wait_idle("ignored");
    endtask

    task automatic test_retrigger();
        int lows;
        start_download(8'd0);
        expect_wr(1'b0, 16'h0042, 16'h0081);
        send_byte(25'h42, 8'h81);
        ioctl_download = 1'b0;
        tick(6);
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_sys);
            if (!core_reset_hold) lows++;
        end
        #1;
        n_checks++;
        if (lows != 0) begin
            n_fails++;
            $display("[TB] FAIL retrig_gap: got %0d low samples, required 0", lows);
        end
        n_checks++;
        if ((bytes_loaded !== 17'd0) || (busy !== 1'b1)) begin
            n_fails++;
            $display("[TB] FAIL retrig_load: got bytes=%0d busy=%b, required 0 1", bytes_loaded, busy);
        end
        ioctl_download = 1'b0;
        wait_idle("retrig");
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = 8'h00;
        ioctl_index    = 8'h00;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        test_reset();
        test_bios();
        test_sprite_pack();
        test_back_to_back();
        test_range_error();
        test_ignored_index();
        test_retrigger();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
